// File: rtl/p2s_pkg.sv
// Shared constants and types for the multi-channel phase-to-speed averager.
// Defaults here match the top-level parameter defaults of phase2speed_mc.
package p2s_pkg;

    localparam int P2S_CH         = 4;
    localparam int P2S_N_MAX      = 6;
    localparam int P2S_PW         = 19;
    localparam int P2S_SW         = 16;
    localparam int P2S_KW         = 15;
    localparam int P2S_KSHIFT     = 12;
    localparam int P2S_FIFO_DEPTH = 4;

    // Scale that maps a 9Q10 phase step per sample to a 6Q10 speed
    localparam int P2S_SCALE_DEFAULT = 20450;

    // Saturation limits of the 6Q10 speed output
    localparam int P2S_SAT_MAX = 32767;
    localparam int P2S_SAT_MIN = -32768;

    // Channel index width, never narrower than one bit
    function automatic int p2s_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int P2S_CW = p2s_idx_width(P2S_CH);

    // Output FIFO entry for the default geometry
    typedef struct packed {
        logic [P2S_CW-1:0]        ch;
        logic signed [P2S_SW-1:0] speed;
    } p2s_entry_t;

endpackage

// File: rtl/p2s_sync_fifo.sv
// Small synchronous FIFO with full/empty, used as the result buffer.
// The head is presented combinationally; a write while full is only
// accepted when a read happens in the same cycle.
module p2s_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNTW-1:0]  count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_reg == CNTW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_reg];

    // Storage array: written only, never reset
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/phase2speed_mc.sv
// Multi-channel phase-to-speed averager.
// Averages 2^w phase samples per channel, scales, saturates to 6Q10 and
// queues results in an output FIFO. Build option P2S_ROUND_EN selects
// round-half-up at both shifts; otherwise both shifts floor.
module phase2speed_mc
    import p2s_pkg::*;
#(
    parameter int CH         = P2S_CH,
    parameter int N_MAX      = P2S_N_MAX,
    parameter int PW         = P2S_PW,
    parameter int SW         = P2S_SW,
    parameter int KW         = P2S_KW,
    parameter int KSHIFT     = P2S_KSHIFT,
    parameter int FIFO_DEPTH = P2S_FIFO_DEPTH,
    localparam int CW        = p2s_idx_width(CH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample,
    input  logic [CW-1:0]        sample_ch,
    input  logic signed [PW-1:0] phase,
    input  logic [3:0]           win_sel,
    input  logic [KW-1:0]        scale,
    input  logic                 clear_flags,
    output logic signed [SW-1:0] speed,
    output logic [CW-1:0]        speed_ch,
    output logic                 speed_valid,
    input  logic                 speed_ready,
    output logic                 sat_flag,
    output logic                 drop_flag
);

    localparam int ACC_W = PW + N_MAX;
    localparam int CNT_W = N_MAX + 1;
    localparam int WLW   = $clog2(N_MAX + 1);
    localparam int TW    = ACC_W + 1;
    localparam int PRW   = PW + KW + 1;
    localparam int EW    = CW + SW;

    localparam logic signed [SW-1:0]  SPD_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0]  SPD_MIN = {1'b1, {(SW-1){1'b0}}};
    localparam logic signed [PRW-1:0] Q_MAX   = {{(PRW-SW){1'b0}}, SPD_MAX};
    localparam logic signed [PRW-1:0] Q_MIN   = {{(PRW-SW){1'b1}}, SPD_MIN};

    // Per-channel accumulation state
    logic signed [ACC_W-1:0] acc_reg [CH];
    logic [CNT_W-1:0]        cnt_reg [CH];
    logic [WLW-1:0]          wl_reg  [CH];

    logic [CH-1:0]           hit;
    logic [WLW-1:0]          win_cl;
    logic signed [ACC_W-1:0] sel_acc;
    logic [CNT_W-1:0]        sel_cnt;
    logic [WLW-1:0]          sel_wl;
    logic [WLW-1:0]          wl_eff;
    logic [CNT_W-1:0]        limit;
    logic                    sel_last;
    logic signed [TW-1:0]    total;
    logic signed [TW-1:0]    total_r;
    logic signed [TW-1:0]    shifted;
    logic signed [PW-1:0]    avg;

    // Stage 1: average and channel
    logic                    s1_valid_reg;
    logic signed [PW-1:0]    s1_avg_reg;
    logic [CW-1:0]           s1_ch_reg;

    // Stage 2: scaled, saturated speed and channel
    logic signed [PRW-1:0]   avg_ext;
    logic signed [PRW-1:0]   k_ext;
    logic signed [PRW-1:0]   prod;
    logic signed [PRW-1:0]   prod_r;
    logic signed [PRW-1:0]   q;
    logic signed [SW-1:0]    spd_next;
    logic                    sat_next;
    logic                    s2_valid_reg;
    logic signed [SW-1:0]    s2_spd_reg;
    logic [CW-1:0]           s2_ch_reg;

    logic                    sat_flag_reg;
    logic                    drop_flag_reg;
    logic [EW-1:0]           head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop_evt;
    logic                    unused_bits;

    // One-hot decode of the sample channel; indices >= CH never match
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_hit
            assign hit[gi] = sample && (sample_ch == CW'(gi));
        end
    endgenerate

    assign win_cl = (win_sel > 4'(N_MAX)) ? WLW'(N_MAX) : WLW'(win_sel);

    // Select the addressed channel's state and form the running total / average
    always_comb begin
        sel_acc = '0;
        sel_cnt = '0;
        sel_wl  = '0;
        for (int i = 0; i < CH; i++) begin
            if (hit[i]) begin
                sel_acc = acc_reg[i];
                sel_cnt = cnt_reg[i];
                sel_wl  = wl_reg[i];
            end
        end
        // The window length is latched on the first sample of a window
        wl_eff   = (sel_cnt == '0) ? win_cl : sel_wl;
        limit    = (CNT_W'(1) << wl_eff) - CNT_W'(1);
        sel_last = (sel_cnt == limit);
        total    = {{(TW-ACC_W){sel_acc[ACC_W-1]}}, sel_acc}
                 + {{(TW-PW){phase[PW-1]}}, phase};
        total_r  = total;
`ifdef P2S_ROUND_EN
        if (wl_eff != '0) begin
            total_r = total + ((TW'(1) << wl_eff) >> 1);
        end
`endif
        shifted  = total_r >>> wl_eff;
        avg      = shifted[PW-1:0];
    end

    // Accumulate per channel; the closing sample clears the channel's window
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                acc_reg[i] <= '0;
                cnt_reg[i] <= '0;
                wl_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (hit[i]) begin
                    wl_reg[i] <= wl_eff;
                    if (sel_last) begin
                        acc_reg[i] <= '0;
                        cnt_reg[i] <= '0;
                    end else begin
                        acc_reg[i] <= total[ACC_W-1:0];
                        cnt_reg[i] <= sel_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Stage 1 register: completed average with its channel
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_avg_reg   <= '0;
            s1_ch_reg    <= '0;
        end else begin
            s1_valid_reg <= (|hit) && sel_last;
            s1_avg_reg   <= avg;
            s1_ch_reg    <= sample_ch;
        end
    end

    // Scale the average, shift down and clamp into the speed range
    always_comb begin
        avg_ext = {{(PRW-PW){s1_avg_reg[PW-1]}}, s1_avg_reg};
        k_ext   = {{(PRW-KW){1'b0}}, scale};
        prod    = avg_ext * k_ext;
        prod_r  = prod;
`ifdef P2S_ROUND_EN
        prod_r  = prod + (PRW'(1) << (KSHIFT - 1));
`endif
        q        = prod_r >>> KSHIFT;
        sat_next = 1'b0;
        spd_next = q[SW-1:0];
        if (q > Q_MAX) begin
            spd_next = SPD_MAX;
            sat_next = 1'b1;
        end else if (q < Q_MIN) begin
            spd_next = SPD_MIN;
            sat_next = 1'b1;
        end
    end

    // Stage 2 register: result that is offered to the FIFO next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_spd_reg   <= '0;
            s2_ch_reg    <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_spd_reg   <= spd_next;
            s2_ch_reg    <= s1_ch_reg;
        end
    end

    p2s_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (s2_valid_reg),
        .wr_data ({s2_ch_reg, s2_spd_reg}),
        .rd_en   (speed_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO only loses the new result when the head is not leaving
    assign drop_evt = s2_valid_reg && fifo_full && !speed_ready;

    // Sticky flags: a new event wins over a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_flag_reg  <= 1'b0;
            drop_flag_reg <= 1'b0;
        end else begin
            sat_flag_reg  <= (sat_flag_reg && !clear_flags) || (s1_valid_reg && sat_next);
            drop_flag_reg <= (drop_flag_reg && !clear_flags) || drop_evt;
        end
    end

    assign speed_valid = !fifo_empty;
    assign speed       = speed_valid ? head[SW-1:0] : '0;
    assign speed_ch    = speed_valid ? head[EW-1:SW] : '0;
    assign sat_flag    = sat_flag_reg;
    assign drop_flag   = drop_flag_reg;

    // Bits above the average width are discarded by construction
    assign unused_bits = ^shifted[TW-1:PW];

endmodule
